ysyx_22040759_exec_ctrl: RTL and testbench
==========================================

# ysyx_22040759_exec_ctrl

Multi-cycle execution sequencer for the NPC core. It owns the PC and the instruction register, fetches over a valid/ready instruction port, and presents the latched instruction to the decode/control unit. It then gates that unit's register-write, memory-write and PC-select controls into a fixed FETCH/EXECUTE/MEMORY/WRITEBACK sequence, halting on `ebreak` or an undecodable instruction.

## Interface
- `RESET_PC`, 64'h8000_0000, PC loaded on reset.
- `clk` in 1, core clock; all state on rising edge.
- `rst_n` in 1, asynchronous, active-low reset.
- `ifu_req_valid` out 1, fetch request; address is `pc_o`.
- `ifu_req_ready` in 1, fetch request accepted.
- `ifu_rsp_valid` in 1, instruction word valid.
- `ifu_rsp_inst` in 32, fetched instruction.
- `inst_o` out 32, latched instruction to the decode/control unit.
- `pc_o` out 64, PC of the instruction in flight.
- `dec_pc_sel` in 1, decoder: next PC comes from the ALU.
- `dec_reg_wen` in 1, decoder: instruction writes rd.
- `dec_mem_wen` in 1, decoder: instruction needs the memory phase.
- `dec_illegal` in 1, decoder matched no pattern (default arm).
- `alu_res` in 64, ALU result (jump target for `jal`/`jalr`).
- `lsu_req_valid` out 1, memory request; `lsu_req_ready` in 1, accepted; `lsu_done` in 1, access complete.
- `rf_wen` out 1, one-cycle register-file write strobe.
- `halt_o` out 1, sticky halt; `halt_cause` out 1 (0 = ebreak, 1 = illegal).
- `instret_o` out 64, retired-instruction count.

## Operation
- States: IDLE, IF_REQ, IF_WAIT, EX, MEM, WB, HALT.
- Reset state is IDLE. IDLE always moves to IF_REQ on the next cycle.
- **IF_REQ**
  - `ifu_req_valid` = 1.
  - Moves to IF_WAIT when `ifu_req_ready` = 1.
  - `ifu_req_valid` stays high until accepted.
- **IF_WAIT**
  - On `ifu_rsp_valid`, latch `ifu_rsp_inst` into `inst_o` and go to EX.
  - `ifu_rsp_valid` is ignored in every other state.
- **EX** (decoder and ALU settle combinationally on `inst_o`)
  - If `inst_o` = 32'h0010_0073 (ebreak): go to HALT with cause 0.
  - Else if `dec_illegal`: go to HALT with cause 1.
  - Otherwise latch `npc` = `dec_pc_sel` ? {`alu_res`[63:1],1'b0} : `pc_o`+4, then go to MEM if `dec_mem_wen`, else to WB.
  - The +4 wraps modulo 2^64.
- **MEM**
  - `lsu_req_valid` = 1 until `lsu_req_ready`, then wait for `lsu_done`, then go to WB.
  - If `lsu_req_ready` and `lsu_done` are both high in the same cycle, go directly to WB.
- **WB**
  - `rf_wen` = `dec_reg_wen` for exactly this cycle.
  - `pc_o` <= `npc`; go to IF_REQ.
  - rd = x0 is still strobed; the register file discards the write.
- **HALT**
  - `halt_o` = 1; all request/strobe outputs are 0.
  - `pc_o` and `inst_o` hold the halting instruction.
  - Only reset exits HALT.
- **Reset values**
  - `pc_o`=`RESET_PC`, `inst_o`=32'h0000_0013 (nop), `instret_o`=0.
  - `ifu_req_valid`, `lsu_req_valid`, `rf_wen`, `halt_o`, `halt_cause` all 0.
- **Reset mid-operation**: immediate return to IDLE. Outstanding fetch/LSU transactions are abandoned, and the memory side must tolerate this. No `rf_wen` is asserted while `rst_n` = 0.

## Timing
- `ifu_req_valid`, `lsu_req_valid` and `rf_wen` are decoded from registered state only (no input-to-output combinational path).
- Minimum of 4 cycles per non-memory instruction: IF_REQ (ready same cycle), IF_WAIT (response next cycle), EX, WB.
- A memory instruction adds at least 1 cycle.
- The new PC is visible on `pc_o` in the IF_REQ cycle following WB.
- `halt_o` rises the cycle after EX.

## Configuration
- `YSYX_22040759_INSTRET_EN`
  - **Defined:** `instret_o` increments by 1 in every WB cycle, wrapping at 2^64. HALT does not increment.
  - **Undefined:** the counter logic is omitted and `instret_o` is tied to 0.

## Structure
- Shared define package holds:
  - state encodings (3-bit);
  - `EBREAK_INST`, `NOP_INST`;
  - default `RESET_PC`.
- One sub-module: `ysyx_22040759_instret_cnt` (64-bit counter with `inc` enable), instantiated only under the macro.

## Test plan
- **Reset and first fetch:** hold `rst_n`=0 for 3 cycles, then release → one IDLE cycle, then `ifu_req_valid`=1 with `pc_o`=0x8000_0000; all other outputs at reset values.
- **addi with ideal memory:** `ifu_req_ready`=1, response one cycle later with 0x0010_0093 → `rf_wen` pulses exactly once in cycle 4; next `pc_o`=0x8000_0004; `instret_o`=1 (macro on).
- **jalr target:** `dec_pc_sel`=1, `alu_res`=0x8000_0101 → next `pc_o`=0x8000_0100.
- **Backpressure:** `ifu_req_ready` low for 5 cycles, then `lsu_done` delayed 3 cycles after acceptance → request held stable; exactly one `rf_wen`; no PC change before WB.
- **ebreak:** fetch 0x0010_0073 → `halt_o`=1, `halt_cause`=0, `pc_o` frozen, no `rf_wen`, `instret_o` unchanged.
- **Illegal instruction:** `dec_illegal`=1 → `halt_cause`=1.
- **Reset during MEM:** assert `rst_n`=0 while `lsu_req_valid`=1 → `lsu_req_valid` drops asynchronously; after release the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ysyx_22040759_exec_ctrl_pkg.sv
// Shared definitions for the NPC multi-cycle execution sequencer:
// state encodings, special instruction words and the default reset PC.
package ysyx_22040759_exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_IF_REQ  = 3'd1,
    ST_IF_WAIT = 3'd2,
    ST_EX      = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  // jalr clears bit 0 of the computed target; jal targets are already even
  function automatic logic [63:0] jump_target(input logic [63:0] res);
    return res & ~64'd1;
  endfunction

endpackage

// File: rtl/ysyx_22040759_instret_cnt.sv
// 64-bit retired-instruction counter, wraps at 2^64.
module ysyx_22040759_instret_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc)
      count <= count + 64'd1;
  end

endmodule

// File: rtl/ysyx_22040759_exec_ctrl.sv
// Multi-cycle FETCH/EXECUTE/MEMORY/WRITEBACK sequencer owning PC and IR.
// Define YSYX_22040759_INSTRET_EN to build the retired-instruction counter.
module ysyx_22040759_exec_ctrl
  import ysyx_22040759_exec_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  input  logic        dec_pc_sel,
  input  logic        dec_reg_wen,
  input  logic        dec_mem_wen,
  input  logic        dec_illegal,
  input  logic [63:0] alu_res,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_done,
  output logic        rf_wen,
  output logic        halt_o,
  output logic        halt_cause,
  output logic [63:0] instret_o
);

  state_e      state;
  state_e      state_nxt;
  logic [63:0] npc;
  logic        lsu_acc;
  logic        reg_wen_q;
  logic        is_ebreak;

  assign is_ebreak = (inst_o == EBREAK_INST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = ST_IF_REQ;
      ST_IF_REQ:  if (ifu_req_ready) state_nxt = ST_IF_WAIT;
      ST_IF_WAIT: if (ifu_rsp_valid) state_nxt = ST_EX;
      ST_EX: begin
        if (is_ebreak || dec_illegal) state_nxt = ST_HALT;
        else if (dec_mem_wen)         state_nxt = ST_MEM;
        else                          state_nxt = ST_WB;
      end
      // completion may arrive together with acceptance
      ST_MEM:     if ((lsu_acc || lsu_req_ready) && lsu_done) state_nxt = ST_WB;
      ST_WB:      state_nxt = ST_IF_REQ;
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Strobes come only from registered state so no input reaches an output.
  always_comb begin
    ifu_req_valid = (state == ST_IF_REQ);
    lsu_req_valid = (state == ST_MEM) && !lsu_acc;
    rf_wen        = (state == ST_WB) && reg_wen_q;
    halt_o        = (state == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o       <= RESET_PC;
      inst_o     <= NOP_INST;
      npc        <= RESET_PC;
      lsu_acc    <= 1'b0;
      reg_wen_q  <= 1'b0;
      halt_cause <= 1'b0;
    end else begin
      case (state)
        ST_IF_WAIT: if (ifu_rsp_valid) inst_o <= ifu_rsp_inst;
        ST_EX: begin
          lsu_acc <= 1'b0;
          if (is_ebreak) begin
            halt_cause <= 1'b0;
          end else if (dec_illegal) begin
            halt_cause <= 1'b1;
          end else begin
            npc       <= dec_pc_sel ? jump_target(alu_res) : pc_o + 64'd4;
            reg_wen_q <= dec_reg_wen;
          end
        end
        ST_MEM:     if (lsu_req_ready && !lsu_acc) lsu_acc <= 1'b1;
        ST_WB:      pc_o <= npc;
        default:    ;
      endcase
    end
  end

`ifdef YSYX_22040759_INSTRET_EN
  logic retire;
  assign retire = (state == ST_WB);

  ysyx_22040759_instret_cnt u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instret_o)
  );
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040759_exec_ctrl.sv
// Randomized self-checking bench for ysyx_22040759_exec_ctrl against an
// instruction-level model of PC, retirement count and halting.
module tb_ysyx_22040759_exec_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = '0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        dec_pc_sel = 1'b0;
  logic        dec_reg_wen = 1'b0;
  logic        dec_mem_wen = 1'b0;
  logic        dec_illegal = 1'b0;
  logic [63:0] alu_res = '0;
  logic        lsu_req_valid;
  logic        lsu_req_ready = 1'b0;
  logic        lsu_done = 1'b0;
  logic        rf_wen;
  logic        halt_o;
  logic        halt_cause;
  logic [63:0] instret_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc = RST_PC;
  logic [63:0] exp_instret = '0;

  ysyx_22040759_exec_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .dec_pc_sel    (dec_pc_sel),
    .dec_reg_wen   (dec_reg_wen),
    .dec_mem_wen   (dec_mem_wen),
    .dec_illegal   (dec_illegal),
    .alu_res       (alu_res),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_done      (lsu_done),
    .rf_wen        (rf_wen),
    .halt_o        (halt_o),
    .halt_cause    (halt_cause),
    .instret_o     (instret_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] instret_view();
`ifdef YSYX_22040759_INSTRET_EN
    return exp_instret;
`else
    return 64'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0;
    lsu_done      = 1'b0;
    dec_pc_sel    = 1'b0;
    dec_reg_wen   = 1'b0;
    dec_mem_wen   = 1'b0;
    dec_illegal   = 1'b0;
  endtask

  // Holds reset, checks reset values, releases and expects one IDLE cycle.
  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    clearInputs();
    repeat (cycles) @(negedge clk);
    checkOutput("rst_ifu_req", 64'(ifu_req_valid), 64'd0);
    checkOutput("rst_lsu_req", 64'(lsu_req_valid), 64'd0);
    checkOutput("rst_rf_wen", 64'(rf_wen), 64'd0);
    checkOutput("rst_halt", 64'({halt_o, halt_cause}), 64'd0);
    checkOutput("rst_pc", pc_o, RST_PC);
    checkOutput("rst_inst", 64'(inst_o), 64'h13);
    checkOutput("rst_instret", instret_o, 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_no_req", 64'(ifu_req_valid), 64'd0);
    @(negedge clk);
    checkOutput("first_req", 64'(ifu_req_valid), 64'd1);
    checkOutput("first_pc", pc_o, RST_PC);
    exp_pc      = RST_PC;
    exp_instret = '0;
  endtask

  // Runs one instruction through fetch/execute/memory/writeback and
  // checks it against the instruction-level model.
  task automatic applyStimulus(
    input  logic [31:0] inst,
    input  bit          pc_sel, reg_wen, mem_wen, illegal,
    input  logic [63:0] alu,
    input  int          if_delay, rsp_delay, rdy_delay, done_delay,
    input  bit          reset_in_mem,
    input  bit          check_cycles,
    output bit          halted
  );
    int          n, cyc, rfc, rf_at, rdy_left, done_left;
    bit          stable, lsu_seen, acc, lsu_bad, pc_moved, aborted, ended;
    bit          exp_halt, exp_cause;
    logic [63:0] next_pc;

    exp_halt  = (inst == EBRK) || illegal;
    exp_cause = (inst != EBRK);
    next_pc   = pc_sel ? alu - (alu % 64'd2) : exp_pc + 64'd4;
    halted    = exp_halt;

    n = 0;
    while (!ifu_req_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fetch_req", 64'(ifu_req_valid), 64'd1);
    checkOutput("fetch_pc", pc_o, exp_pc);

    cyc = 0;
    stable = 1'b1;
    repeat (if_delay) begin
      ifu_req_ready = 1'b0;
      @(negedge clk);
      cyc++;
      if (!ifu_req_valid || pc_o !== exp_pc) stable = 1'b0;
    end
    ifu_req_ready = 1'b1;
    @(negedge clk);
    cyc++;
    ifu_req_ready = 1'b0;
    if (if_delay > 0) checkOutput("req_held", 64'(stable), 64'd1);
    checkOutput("req_dropped", 64'(ifu_req_valid), 64'd0);

    repeat (rsp_delay) begin
      ifu_rsp_inst = $urandom;
      @(negedge clk);
      cyc++;
    end
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = inst;
    dec_pc_sel    = pc_sel;
    dec_reg_wen   = reg_wen;
    dec_mem_wen   = mem_wen;
    dec_illegal   = illegal;
    alu_res       = alu;
    @(negedge clk);
    cyc++;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_inst  = $urandom;
    checkOutput("inst_latch", 64'(inst_o), 64'(inst));

    rfc = 0; rf_at = -1; rdy_left = rdy_delay; done_left = done_delay;
    lsu_seen = 0; acc = 0; lsu_bad = 0; pc_moved = 0; aborted = 0; ended = 0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      cyc++;
      n++;
      if (rf_wen) begin
        rfc++;
        rf_at = cyc;
      end
      if (halt_o || ifu_req_valid) begin
        ended = 1;
        break;
      end
      if (pc_o !== exp_pc) pc_moved = 1;
      if (reset_in_mem && lsu_req_valid) begin
        rst_n = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_done = 1'b0;
        #1;
        checkOutput("rst_mem_lsu_drop", 64'(lsu_req_valid), 64'd0);
        checkOutput("rst_mem_pc", pc_o, RST_PC);
        checkOutput("rst_mem_rf_wen", 64'(rf_wen), 64'd0);
        aborted = 1;
        ended = 1;
        break;
      end
      lsu_req_ready = 1'b0;
      lsu_done      = 1'b0;
      if (!acc) begin
        if (lsu_req_valid) begin
          lsu_seen = 1;
          if (rdy_left > 0) begin
            rdy_left--;
          end else begin
            lsu_req_ready = 1'b1;
            acc = 1;
            if (done_delay == 0) lsu_done = 1'b1;
          end
        end else if (lsu_seen) begin
          lsu_bad = 1;
        end
      end else begin
        if (lsu_req_valid) lsu_bad = 1;
        if (done_left > 0) begin
          done_left--;
          if (done_left == 0) lsu_done = 1'b1;
        end
      end
    end
    lsu_req_ready = 1'b0;
    lsu_done      = 1'b0;
    checkOutput("progress_bound", 64'(ended), 64'd1);
    if (aborted) return;

    if (exp_halt) begin
      checkOutput("halt_latency", 64'(n), 64'd1);
      checkOutput("halt_o", 64'(halt_o), 64'd1);
      checkOutput("halt_cause", 64'(halt_cause), 64'(exp_cause));
      checkOutput("halt_no_rf_wen", 64'(rfc), 64'd0);
      repeat (3) @(negedge clk);
      checkOutput("halt_sticky", 64'(halt_o), 64'd1);
      checkOutput("halt_pc", pc_o, exp_pc);
      checkOutput("halt_inst", 64'(inst_o), 64'(inst));
      checkOutput("halt_strobes", 64'({ifu_req_valid, lsu_req_valid, rf_wen}), 64'd0);
      checkOutput("halt_instret", instret_o, instret_view());
    end else begin
      exp_pc = next_pc;
      exp_instret++;
      checkOutput("rf_wen_count", 64'(rfc), 64'(reg_wen));
      checkOutput("lsu_used", 64'(lsu_seen), 64'(mem_wen));
      checkOutput("lsu_handshake", 64'(lsu_bad), 64'd0);
      checkOutput("pc_stable_before_wb", 64'(pc_moved), 64'd0);
      checkOutput("next_pc", pc_o, exp_pc);
      checkOutput("instret", instret_o, instret_view());
      checkOutput("no_halt", 64'(halt_o), 64'd0);
      if (check_cycles) begin
        checkOutput("cycles_per_inst", 64'(cyc), 64'd4);
        checkOutput("rf_wen_cycle", 64'(rf_at + 1), 64'd4);
      end
    end
  endtask

  initial begin
    bit   h;
    logic [31:0] ri;
    bit   rsel, rwen, rmem, rill;

    $display("[TB] exec_ctrl bench start");
    doReset(3);

    applyStimulus(32'h0010_0093, 0, 1, 0, 0, 64'h1234, 0, 0, 0, 0, 0, 1, h);
    checkOutput("addi_pc", pc_o, 64'h8000_0004);

    applyStimulus(32'h0000_80e7, 1, 1, 0, 0, 64'h8000_0101, 0, 0, 0, 0, 0, 0, h);
    checkOutput("jalr_target", pc_o, 64'h8000_0100);

    applyStimulus(32'h0001_3083, 0, 1, 1, 0, 64'h8000_2000, 5, 1, 0, 3, 0, 0, h);
    applyStimulus(32'h00a1_2023, 0, 0, 1, 0, 64'h8000_2008, 0, 0, 2, 0, 0, 0, h);

    applyStimulus(32'h0000_80e7, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0, 0, 0, 0, h);
    applyStimulus(32'h0000_0013, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, h);
    checkOutput("pc_wrap", pc_o, 64'h0);

    applyStimulus(EBRK, 0, 1, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, h);
    doReset(2);
    applyStimulus(32'h0000_0000, 0, 1, 0, 1, 64'h0, 1, 0, 0, 0, 0, 0, h);
    doReset(2);
    applyStimulus(EBRK, 0, 0, 0, 1, 64'h0, 0, 0, 0, 0, 0, 0, h);
    doReset(2);

    applyStimulus(32'h0001_3083, 0, 1, 1, 0, 64'h0, 0, 0, 4, 2, 1, 0, h);
    doReset(2);
    applyStimulus(32'h0010_0093, 0, 1, 0, 0, 64'h0, 0, 0, 0, 0, 0, 1, h);

    for (int i = 0; i < 40; i++) begin
      ri   = $urandom;
      if ($urandom_range(0, 11) == 0) ri = EBRK;
      rsel = 1'($urandom_range(0, 1));
      rwen = 1'($urandom_range(0, 1));
      rmem = 1'($urandom_range(0, 2) == 0);
      rill = ($urandom_range(0, 9) == 0);
      applyStimulus(ri, rsel, rwen, rmem, rill, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, h);
      if (h) doReset($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
